// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES key schedule tables, rotate/permute helpers and controller state type.
package des_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_e;

  // Entries are FIPS bit numbers: 1 = MSB of the source vector.
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] SHIFT_ENC [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Decrypt starts from the unrotated PC-1 value, which is already the K16 position.
  localparam logic [1:0] SHIFT_DEC [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    logic [5:0]  idx;
    for (int i = 0; i < 56; i++) begin
      idx       = 6'(64 - PC1_TAB[i]);
      r[55 - i] = k[idx];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    logic [5:0]  idx;
    for (int i = 0; i < 48; i++) begin
      idx       = 6'(56 - PC2_TAB[i]);
      r[47 - i] = cd[idx];
    end
    return r;
  endfunction

  function automatic logic key_parity_ok(input logic [63:0] k);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      if (!(^k[8*b +: 8])) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/des_cd_rotator.sv
// rtl/des_cd_rotator.sv - combinational C/D half rotate by 0/1/2 places, left or right.
module des_cd_rotator
  import des_pkg::*;
(
  input  logic [27:0] c_i,
  input  logic [27:0] d_i,
  input  logic [1:0]  amt_i,
  input  logic        dir_i,
  output logic [27:0] c_o,
  output logic [27:0] d_o
);

  // dir_i = 1 selects right rotation (decrypt order).
  always_comb begin
    if (dir_i) begin
      c_o = rotr28(c_i, amt_i);
      d_o = rotr28(d_i, amt_i);
    end else begin
      c_o = rotl28(c_i, amt_i);
      d_o = rotl28(d_i, amt_i);
    end
  end

endmodule

// File: rtl/des_key_sched_ctrl.sv
// rtl/des_key_sched_ctrl.sv - DES key schedule sequencer streaming 16 subkeys over valid/ready.
module des_key_sched_ctrl
  import des_pkg::*;
#(
  parameter bit PARITY_CHK = 1'b0,
  parameter bit DONE_PULSE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        decrypt_i,
  input  logic [63:0] key_i,
  output logic        busy_o,
  output logic [47:0] subkey_o,
  output logic        subkey_valid_o,
  input  logic        subkey_ready_i,
  output logic [3:0]  round_o,
  output logic        done_o,
  output logic        key_err_o
);

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic        dir_q, dir_d;
  logic [4:0]  rcnt_q, rcnt_d;
  logic [47:0] subkey_q, subkey_d;
  logic [3:0]  round_q, round_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [1:0]  amt;
  logic [27:0] c_rot, d_rot;

  assign amt = dir_q ? SHIFT_DEC[rcnt_q[3:0]] : SHIFT_ENC[rcnt_q[3:0]];

  des_cd_rotator u_rot (
    .c_i   (c_q),
    .d_i   (d_q),
    .amt_i (amt),
    .dir_i (dir_q),
    .c_o   (c_rot),
    .d_o   (d_rot)
  );

  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    d_d      = d_q;
    dir_d    = dir_q;
    rcnt_d   = rcnt_q;
    subkey_d = subkey_q;
    round_d  = round_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (DONE_PULSE) done_d = 1'b0;
        if (start_i) begin
          if (PARITY_CHK && !key_parity_ok(key_i)) begin
            err_d = 1'b1;
          end else begin
            {c_d, d_d} = pc1(key_i);
            dir_d      = decrypt_i;
            rcnt_d     = 5'd0;
            busy_d     = 1'b1;
            err_d      = 1'b0;
            done_d     = 1'b0;
            state_d    = RUN;
          end
        end
      end
      RUN: begin
        // Output slot is free when empty or being consumed this cycle.
        if (!valid_q || subkey_ready_i) begin
          if (!rcnt_q[4]) begin
            c_d      = c_rot;
            d_d      = d_rot;
            subkey_d = pc2({c_rot, d_rot});
            round_d  = rcnt_q[3:0];
            valid_d  = 1'b1;
            rcnt_d   = rcnt_q + 5'd1;
          end else begin
            valid_d = 1'b0;
            state_d = FIN;
          end
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      c_q      <= '0;
      d_q      <= '0;
      dir_q    <= 1'b0;
      rcnt_q   <= '0;
      subkey_q <= '0;
      round_q  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      d_q      <= d_d;
      dir_q    <= dir_d;
      rcnt_q   <= rcnt_d;
      subkey_q <= subkey_d;
      round_q  <= round_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign busy_o         = busy_q;
  assign subkey_o       = subkey_q;
  assign subkey_valid_o = valid_q;
  assign round_o        = round_q;
  assign done_o         = done_q;
  assign key_err_o      = PARITY_CHK ? err_q : 1'b0;

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// tb/tb_des_key_sched_ctrl.sv - scoreboard bench for des_key_sched_ctrl against a bit-list DES key schedule model.
module tb_des_key_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        decrypt_i;
  logic [63:0] key_i;
  logic        subkey_ready_i;
  logic        busy_o;
  logic [47:0] subkey_o;
  logic        subkey_valid_o;
  logic [3:0]  round_o;
  logic        done_o;
  logic        key_err_o;

  des_key_sched_ctrl #(.PARITY_CHK(1'b1), .DONE_PULSE(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .decrypt_i      (decrypt_i),
    .key_i          (key_i),
    .busy_o         (busy_o),
    .subkey_o       (subkey_o),
    .subkey_valid_o (subkey_valid_o),
    .subkey_ready_i (subkey_ready_i),
    .round_o        (round_o),
    .done_o         (done_o),
    .key_err_o      (key_err_o)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BAD = 64'h133457799BBCDFF0;
  localparam logic [63:0] KEY_B   = 64'h0E329232EA6D0D73;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          t_start = 0;
  bit          rand_ready = 1'b0;
  logic [51:0] sbq [$];
  bit          stall_pend = 1'b0;
  logic [47:0] st_key;
  logic [3:0]  st_rnd;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Ki from scratch: FIPS bit lists, cumulative left shift of Ki modulo 28.
  function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int ki);
    bit          cd  [1:56];
    bit          rot [1:56];
    logic [47:0] k;
    int          tot;
    for (int i = 0; i < 56; i++) cd[i + 1] = key[64 - PC1_T[i]];
    tot = 0;
    for (int i = 0; i < ki; i++) tot += SH_T[i];
    for (int j = 1; j <= 28; j++) begin
      rot[j]      = cd[((j - 1 + tot) % 28) + 1];
      rot[j + 28] = cd[28 + ((j - 1 + tot) % 28) + 1];
    end
    for (int i = 1; i <= 48; i++) k[48 - i] = rot[PC2_T[i - 1]];
    return k;
  endfunction

  function automatic logic [63:0] odd_par(input logic [63:0] k);
    logic [63:0] r;
    r = k;
    for (int b = 0; b < 8; b++) r[8*b] = ~^r[8*b + 1 +: 7];
    return r;
  endfunction

  initial begin
    subkey_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      subkey_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    logic [51:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_pend = 1'b0;
      end else begin
        if (stall_pend) begin
          chk("stall_valid", subkey_valid_o, 1'b1);
          chk("stall_subkey", subkey_o, st_key);
          chk("stall_round", round_o, st_rnd);
        end
        if (subkey_valid_o && subkey_ready_i) begin
          if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL extra_beat: actual round %0d subkey %h required no beat", round_o, subkey_o);
          end else begin
            e = sbq.pop_front();
            chk("beat_subkey", subkey_o, e[51:4]);
            chk("beat_round", round_o, e[3:0]);
          end
        end
        stall_pend = subkey_valid_o && !subkey_ready_i;
        st_key     = subkey_o;
        st_rnd     = round_o;
      end
    end
  end

  task automatic launch(input logic [63:0] key, input logic dec, input bit known);
    logic [47:0] ks [16];
    for (int r = 0; r < 16; r++) ks[r] = ref_subkey(key, dec ? 16 - r : r + 1);
    if (known && !dec) begin
      ks[0]  = 48'h1B02EFFC7072;
      ks[1]  = 48'h79AED9DBC9E5;
      ks[15] = 48'hCB3D8B0E17F5;
    end else if (known) begin
      ks[0]  = 48'hCB3D8B0E17F5;
      ks[15] = 48'h1B02EFFC7072;
    end
    for (int r = 0; r < 16; r++) sbq.push_back({ks[r], 4'(r)});
    key_i     = key;
    decrypt_i = dec;
    start_i   = 1'b1;
    @(posedge clk);
    #1;
    t_start = cyc;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input bit check_lat);
    int n;
    n = 0;
    while (!done_o && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done_o) begin
      chk("done_timeout", 1'b0, 1'b1);
      sbq.delete();
    end else begin
      if (check_lat) chk("done_latency", 64'(cyc - t_start), 64'd18);
      chk("beats_left_at_done", 64'(sbq.size()), 64'd0);
      chk("busy_at_done", busy_o, 1'b0);
      @(posedge clk);
      #1;
      chk("done_pulse_clear", done_o, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] k;
    logic        d;
    int          n;
    rst       = 1'b1;
    start_i   = 1'b0;
    decrypt_i = 1'b0;
    key_i     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_valid", subkey_valid_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_err", key_err_o, 1'b0);
    chk("rst_subkey", subkey_o, 48'h0);
    chk("rst_round", round_o, 4'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // encrypt and decrypt of the known key, ready held high
    launch(KEY_A, 1'b0, 1'b1);
    chk("busy_after_start", busy_o, 1'b1);
    wait_done(1'b1);
    launch(KEY_A, 1'b1, 1'b1);
    wait_done(1'b1);

    // random keys, direction and backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      k = odd_par({$urandom, $urandom});
      d = 1'($urandom_range(0, 1));
      launch(k, d, 1'b0);
      wait_done(1'b0);
    end

    // start during RUN must not disturb the stream
    rand_ready = 1'b0;
    launch(KEY_A, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    key_i     = KEY_B;
    decrypt_i = 1'b1;
    start_i   = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done(1'b1);

    // reset mid-schedule
    rand_ready = 1'b1;
    launch(odd_par({$urandom, $urandom}), 1'b0, 1'b0);
    n = 0;
    while (!(subkey_valid_o && round_o == 4'd7) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reached_round7", subkey_valid_o && round_o == 4'd7, 1'b1);
    rst = 1'b1;
    sbq.delete();
    @(posedge clk);
    #1;
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_valid", subkey_valid_o, 1'b0);
    chk("midrst_subkey", subkey_o, 48'h0);
    chk("midrst_round", round_o, 4'h0);
    chk("midrst_done", done_o, 1'b0);
    rst        = 1'b0;
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    launch(odd_par({$urandom, $urandom}), 1'b1, 1'b0);
    wait_done(1'b1);

    // parity failure, then a good key
    key_i     = KEY_BAD;
    decrypt_i = 1'b0;
    start_i   = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk("parity_err", key_err_o, 1'b1);
    chk("parity_busy", busy_o, 1'b0);
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("parity_no_valid", subkey_valid_o, 1'b0);
      chk("parity_still_idle", busy_o, 1'b0);
    end
    launch(KEY_A, 1'b0, 1'b1);
    chk("parity_err_cleared", key_err_o, 1'b0);
    wait_done(1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
